// File: rtl/axi_lite_dmem_port_b_bridge.sv
// AXI4-Lite slave driving the synchronous port B of the data memory (one-cycle read latency).
// Optional macro DMEM_BRIDGE_BYTE_STROBE_RMW_EN: partial byte strobes are serviced by read-modify-write.
module axi_lite_dmem_port_b_bridge #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_we_b,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [31:0]       mem_din_b,
    input  logic [31:0]       mem_dout_b
);

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_CAP,
        RD_RESP,
`ifdef DMEM_BRIDGE_BYTE_STROBE_RMW_EN
        WR_RMW_RD,
        WR_RMW_CAP,
`endif
        WR_MEM,
        WR_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] LP_WORD_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] LP_DEPTH     = ADDR_W'(DEPTH_WORDS);

    state_t              r_state;
    logic                r_awHeld;
    logic                r_wHeld;
    logic [ADDR_W-1:0]   r_awAddr;
    logic [31:0]         r_wData;
    logic [3:0]          r_wStrb;
    logic                r_lastGrantRd;
    logic                r_rdOob;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_memDin;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rvalid;
    logic [1:0]          r_bresp;
    logic                r_bvalid;

    logic                w_idle;
    logic                w_writePending;
    logic                w_conflict;
    logic                w_grantWrite;
    logic                w_awAccept;
    logic                w_wAccept;
    logic                w_arAccept;
    logic                w_awInRange;
    logic                w_arInRange;
    logic [ADDR_W-1:0]   w_arWordAddr;

    assign w_idle         = (r_state == IDLE);
    assign w_writePending = r_awHeld & r_wHeld;
    assign w_conflict     = w_idle & w_writePending & s_axi_arvalid;
    // Write wins when uncontested, or on a conflict when the read won the previous one.
    assign w_grantWrite   = w_idle & w_writePending & (~s_axi_arvalid | r_lastGrantRd);

    assign s_axi_awready  = ~rst & w_idle & ~r_awHeld;
    assign s_axi_wready   = ~rst & w_idle & ~r_wHeld;
    assign s_axi_arready  = ~rst & w_idle & (~w_writePending | ~r_lastGrantRd);

    assign w_awAccept     = s_axi_awready & s_axi_awvalid;
    assign w_wAccept      = s_axi_wready & s_axi_wvalid;
    assign w_arAccept     = s_axi_arready & s_axi_arvalid;

    assign w_arWordAddr   = s_axi_araddr & LP_WORD_MASK;
    assign w_arInRange    = (s_axi_araddr >> 2) < LP_DEPTH;
    assign w_awInRange    = (r_awAddr >> 2) < LP_DEPTH;

`ifdef DMEM_BRIDGE_BYTE_STROBE_RMW_EN
    logic [31:0] w_merged;

    always_comb begin
        w_merged = mem_dout_b;
        for (int i = 0; i < 4; i++) begin
            if (r_wStrb[i]) w_merged[8*i +: 8] = r_wData[8*i +: 8];
        end
    end
`endif

    assign s_axi_bresp  = r_bresp;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rvalid = r_rvalid;
    assign mem_we_b     = r_memWe;
    assign mem_addr_b   = r_memAddr;
    assign mem_din_b    = r_memDin;

    // Holding registers, arbitration and port-B sequencing share one state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_awHeld      <= 1'b0;
            r_wHeld       <= 1'b0;
            r_awAddr      <= '0;
            r_wData       <= '0;
            r_wStrb       <= '0;
            r_lastGrantRd <= 1'b1;
            r_rdOob       <= 1'b0;
            r_memWe       <= 1'b0;
            r_memAddr     <= '0;
            r_memDin      <= '0;
            r_rdata       <= '0;
            r_rresp       <= '0;
            r_rvalid      <= 1'b0;
            r_bresp       <= '0;
            r_bvalid      <= 1'b0;
        end else begin
            if (w_awAccept) begin
                r_awHeld <= 1'b1;
                r_awAddr <= s_axi_awaddr & LP_WORD_MASK;
            end
            if (w_wAccept) begin
                r_wHeld <= 1'b1;
                r_wData <= s_axi_wdata;
                r_wStrb <= s_axi_wstrb;
            end
            r_memWe <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grantWrite) begin
                        if (w_conflict) r_lastGrantRd <= 1'b0;
                        if (!w_awInRange) begin
                            r_bresp  <= 2'b10;
                            r_bvalid <= 1'b1;
                            r_state  <= WR_RESP;
                        end else if (r_wStrb == 4'h0) begin
                            r_bresp  <= 2'b00;
                            r_bvalid <= 1'b1;
                            r_state  <= WR_RESP;
                        end else if (r_wStrb == 4'hF) begin
                            r_memAddr <= r_awAddr;
                            r_memDin  <= r_wData;
                            r_memWe   <= 1'b1;
                            r_state   <= WR_MEM;
                        end else begin
`ifdef DMEM_BRIDGE_BYTE_STROBE_RMW_EN
                            r_memAddr <= r_awAddr;
                            r_state   <= WR_RMW_RD;
`else
                            r_bresp  <= 2'b10;
                            r_bvalid <= 1'b1;
                            r_state  <= WR_RESP;
`endif
                        end
                    end else if (w_arAccept) begin
                        if (w_conflict) r_lastGrantRd <= 1'b1;
                        // Out-of-range reads keep the port idle but walk the same states for equal latency.
                        r_rdOob <= ~w_arInRange;
                        if (w_arInRange) r_memAddr <= w_arWordAddr;
                        r_state <= RD_MEM;
                    end
                end
                RD_MEM: begin
                    r_state <= RD_CAP;
                end
                RD_CAP: begin
                    r_rdata  <= r_rdOob ? 32'h0 : mem_dout_b;
                    r_rresp  <= r_rdOob ? 2'b10 : 2'b00;
                    r_rvalid <= 1'b1;
                    r_state  <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
`ifdef DMEM_BRIDGE_BYTE_STROBE_RMW_EN
                WR_RMW_RD: begin
                    r_state <= WR_RMW_CAP;
                end
                WR_RMW_CAP: begin
                    r_memDin <= w_merged;
                    r_memWe  <= 1'b1;
                    r_state  <= WR_MEM;
                end
`endif
                WR_MEM: begin
                    r_bresp  <= 2'b00;
                    r_bvalid <= 1'b1;
                    r_state  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_awHeld <= 1'b0;
                        r_wHeld  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
